bulls_cows_core: RTL and testbench
==================================

BULLS_COWS_CORE -- requirements
Module: bulls_cows_core

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning digits per code (legal 2..8).
REQ-002 SHALL have parameter DW, default 4, meaning bits per digit (legal 2..5).
REQ-003 SHALL have parameter MAX_TRIES, default 15, meaning guesses allowed per player (legal 1..255).
REQ-004 SHALL have port clock, input, 1, the single system clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port confirma, input, 1, confirm button level (already debounced).
REQ-007 SHALL have port SW, input, DIGITS*DW, code entry; digit i = SW[i*DW +: DW], digit DIGITS-1 leftmost.
REQ-008 SHALL have port phase, output, 3, current state code (see REQ-013).
REQ-009 SHALL have port player, output, 1, active player (0 = P1, 1 = P2).
REQ-010 SHALL have ports bulls and cows, output, $clog2(DIGITS+1) each, score of the last guess.
REQ-011 SHALL have ports tries_p1 and tries_p2, output, 8 each, scored guesses per player.
REQ-012 SHALL have ports invalid (1-cycle pulse on code rejection), winner (1, winning player), busy (1, high in VALIDATE/SCORE), all outputs.

Function
REQ-013 SHALL implement states P1_SETUP=0, P2_SETUP=1, VALIDATE=2, GUESS=3, SCORE=4, SHOW=5, WIN=6, DRAW=7; phase SHALL be a register equal to the state code.
REQ-014 SHALL register confirma once; rise = confirma & ~confirma_prev; each rising edge SHALL trigger at most one action, and a held level SHALL trigger nothing further.
REQ-015 SHALL act on rise only in P1_SETUP, P2_SETUP, GUESS, SHOW, WIN and DRAW; a rise in VALIDATE or SCORE SHALL be ignored.
REQ-016 SHALL latch SW into a candidate register on rise in P1_SETUP, P2_SETUP or GUESS, record the originating state, and enter VALIDATE.
REQ-017 SHALL occupy VALIDATE for exactly 1 cycle; a candidate is valid iff every digit differs from all-ones (NULL) and all DIGITS digits are pairwise distinct.
REQ-018 SHALL, on an invalid candidate, pulse invalid for 1 cycle, return to the originating state, and leave secrets, tries and score unchanged.
REQ-019 SHALL, on a valid candidate, route as follows: from P1_SETUP store secret1 and go to P2_SETUP; from P2_SETUP store secret2, set player=0 and go to GUESS; from GUESS go to SCORE.
REQ-020 SHALL clear bulls and cows on entry to SCORE and compare against the opponent secret (P1 guesses secret2, P2 guesses secret1).
REQ-021 SHALL occupy SCORE for exactly DIGITS cycles, using index k=0..DIGITS-1 with one digit per cycle: bull if guess[k]==secret[k], else cow if guess[k] equals any secret[j] with j!=k, else no change.
REQ-022 SHALL, on leaving SCORE, increment the active player's tries by 1 and enter SHOW; bulls+cows SHALL never exceed DIGITS.
REQ-023 SHALL act on rise in SHOW as follows: if bulls==DIGITS, set winner=player and go to WIN; else if tries_p1==MAX_TRIES and tries_p2==MAX_TRIES, go to DRAW; else toggle player and go to GUESS.
REQ-024 SHALL, on rise in WIN or DRAW, return to P1_SETUP and clear secrets, tries, bulls, cows, player and winner.
REQ-025 SHALL never increment a tries counter past MAX_TRIES.

Reset
REQ-026 SHALL, while reset=0, immediately force phase=P1_SETUP, player=0, bulls=0, cows=0, tries_p1=0, tries_p2=0, winner=0, invalid=0, busy=0, confirma_prev=0, and clear secrets and candidate, regardless of state (including mid-SCORE).
REQ-027 SHALL resume operation on the first rising clock edge after reset deasserts; confirma held high through the release SHALL produce a rise on that edge.

Verification (DIGITS=4, DW=4 unless stated)
REQ-028 SHALL cover: P1 enters 0x1123, then 0x1F23 -> invalid pulses once each, phase stays 0; P1 enters 0x1234 -> phase=1.
REQ-029 SHALL cover: secret1=0x1234, secret2=0x5678, P1 guesses 0x5687 -> busy high for 5 cycles (VALIDATE+4 SCORE), then bulls=2, cows=2, tries_p1=1, phase=5.
REQ-030 SHALL cover: continuing REQ-029, confirm, P2 guesses 0x1234, confirm -> phase=6, winner=1, tries_p2=1; next confirm -> phase=0, all counters 0.
REQ-031 SHALL cover: MAX_TRIES=2, four non-winning guesses alternating P1/P2 -> after the fourth SHOW confirm phase=7; a further confirm -> phase=0.
REQ-032 SHALL cover: confirma held high 20 cycles in P1_SETUP with a valid SW -> exactly one VALIDATE, phase=1 and no further advance.
REQ-033 SHALL cover: reset asserted during the 3rd SCORE cycle -> all outputs at reset values within the same cycle, phase=0 after release.

Source files
------------

// File: rtl/bulls_cows_core.sv
// ---------------------------------------------------------------------------
// bulls_cows_core
//   Two-player Bulls & Cows game controller. Each player enters a secret code,
//   then the players alternate guesses against the opponent's secret. Every
//   guess is validated (no NULL digit, all digits distinct) and then scored one
//   digit per cycle.
//
// Ports
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   confirma  : debounced confirm button level; acts on its rising edge
//   SW        : code entry, digit i = SW[i*DW +: DW], digit DIGITS-1 leftmost
//   phase     : current state code
//   player    : active player (0 = P1, 1 = P2)
//   bulls     : bulls of the last scored guess
//   cows      : cows of the last scored guess
//   tries_p1  : scored guesses of P1
//   tries_p2  : scored guesses of P2
//   invalid   : 1-cycle pulse when a candidate code is rejected
//   winner    : winning player
//   busy      : high while validating or scoring
// ---------------------------------------------------------------------------
module bulls_cows_core #(
    parameter int DIGITS    = 4,
    parameter int DW        = 4,
    parameter int MAX_TRIES = 15
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         confirma,
    input  logic [DIGITS*DW-1:0]         SW,
    output logic [2:0]                   phase,
    output logic                         player,
    output logic [$clog2(DIGITS+1)-1:0]  bulls,
    output logic [$clog2(DIGITS+1)-1:0]  cows,
    output logic [7:0]                   tries_p1,
    output logic [7:0]                   tries_p2,
    output logic                         invalid,
    output logic                         winner,
    output logic                         busy
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int KW = $clog2(DIGITS);

    localparam logic [2:0] P1_SETUP = 3'd0;
    localparam logic [2:0] P2_SETUP = 3'd1;
    localparam logic [2:0] VALIDATE = 3'd2;
    localparam logic [2:0] GUESS    = 3'd3;
    localparam logic [2:0] SCORE    = 3'd4;
    localparam logic [2:0] SHOW     = 3'd5;
    localparam logic [2:0] WIN      = 3'd6;
    localparam logic [2:0] DRAW     = 3'd7;

    localparam logic [7:0]    TRIES_MAX = 8'(MAX_TRIES);
    localparam logic [KW-1:0] K_LAST    = KW'(DIGITS - 1);

    logic                   confirma_prev;
    logic                   rise;
    logic [DIGITS*DW-1:0]   cand;
    logic [2:0]             origin;
    logic [DIGITS*DW-1:0]   secret1;
    logic [DIGITS*DW-1:0]   secret2;
    logic [KW-1:0]          k;

    logic                   cand_ok;
    logic [DIGITS*DW-1:0]   opp;
    logic [DW-1:0]          g_dig;
    logic                   hit_bull;
    logic                   hit_cow;

    assign rise = confirma & ~confirma_prev;
    assign busy = (phase == VALIDATE) || (phase == SCORE);

    // Candidate check: no all-ones digit and all digits pairwise distinct.
    always_comb begin
        cand_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cand[i*DW +: DW] == {DW{1'b1}}) begin
                cand_ok = 1'b0;
            end
            for (int j = i + 1; j < DIGITS; j++) begin
                if (cand[i*DW +: DW] == cand[j*DW +: DW]) begin
                    cand_ok = 1'b0;
                end
            end
        end
    end

    // Per-digit scoring of guess digit k against the opponent's secret.
    always_comb begin
        opp      = player ? secret1 : secret2;
        g_dig    = cand[k*DW +: DW];
        hit_bull = (g_dig == opp[k*DW +: DW]);
        hit_cow  = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if ((j != int'(k)) && (g_dig == opp[j*DW +: DW])) begin
                hit_cow = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            confirma_prev <= 1'b0;
            phase         <= P1_SETUP;
            origin        <= P1_SETUP;
            cand          <= '0;
            secret1       <= '0;
            secret2       <= '0;
            k             <= '0;
            player        <= 1'b0;
            bulls         <= '0;
            cows          <= '0;
            tries_p1      <= '0;
            tries_p2      <= '0;
            invalid       <= 1'b0;
            winner        <= 1'b0;
        end else begin
            confirma_prev <= confirma;
            invalid       <= 1'b0;
            case (phase)
                P1_SETUP, P2_SETUP, GUESS: begin
                    if (rise) begin
                        cand   <= SW;
                        origin <= phase;
                        phase  <= VALIDATE;
                    end
                end
                VALIDATE: begin
                    if (!cand_ok) begin
                        invalid <= 1'b1;
                        phase   <= origin;
                    end else begin
                        case (origin)
                            P1_SETUP: begin
                                secret1 <= cand;
                                phase   <= P2_SETUP;
                            end
                            P2_SETUP: begin
                                secret2 <= cand;
                                player  <= 1'b0;
                                phase   <= GUESS;
                            end
                            default: begin
                                bulls <= '0;
                                cows  <= '0;
                                k     <= '0;
                                phase <= SCORE;
                            end
                        endcase
                    end
                end
                SCORE: begin
                    if (hit_bull) begin
                        bulls <= bulls + CW'(1);
                    end else if (hit_cow) begin
                        cows <= cows + CW'(1);
                    end
                    if (k == K_LAST) begin
                        if (!player && (tries_p1 != TRIES_MAX)) begin
                            tries_p1 <= tries_p1 + 8'd1;
                        end
                        if (player && (tries_p2 != TRIES_MAX)) begin
                            tries_p2 <= tries_p2 + 8'd1;
                        end
                        phase <= SHOW;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                SHOW: begin
                    if (rise) begin
                        if (bulls == CW'(DIGITS)) begin
                            winner <= player;
                            phase  <= WIN;
                        end else if ((tries_p1 == TRIES_MAX) && (tries_p2 == TRIES_MAX)) begin
                            phase <= DRAW;
                        end else begin
                            player <= ~player;
                            phase  <= GUESS;
                        end
                    end
                end
                default: begin
                    // WIN and DRAW: a confirm starts a fresh game.
                    if (rise) begin
                        secret1  <= '0;
                        secret2  <= '0;
                        tries_p1 <= '0;
                        tries_p2 <= '0;
                        bulls    <= '0;
                        cows     <= '0;
                        player   <= 1'b0;
                        winner   <= 1'b0;
                        phase    <= P1_SETUP;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bulls_cows_core.sv
module tb_bulls_cows_core;

    logic        clock;
    logic        reset;
    logic        confirma;
    logic [15:0] SW;
    logic [2:0]  phase;
    logic        player;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic [7:0]  tries_p1;
    logic [7:0]  tries_p2;
    logic        invalid;
    logic        winner;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] b;
        logic [2:0] c;
        logic [7:0] t1;
        logic [7:0] t2;
    } exp_t;

    exp_t sb[$];

    bulls_cows_core #(
        .DIGITS    (4),
        .DW        (4),
        .MAX_TRIES (2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .confirma (confirma),
        .SW       (SW),
        .phase    (phase),
        .player   (player),
        .bulls    (bulls),
        .cows     (cows),
        .tries_p1 (tries_p1),
        .tries_p2 (tries_p2),
        .invalid  (invalid),
        .winner   (winner),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bulls = positional matches; cows = digits present anywhere minus bulls.
    function automatic logic [5:0] model(input logic [15:0] g, input logic [15:0] s);
        int b;
        int c;
        b = 0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i*4 +: 4] == s[i*4 +: 4]) b++;
            for (int j = 0; j < 4; j++) begin
                if (g[i*4 +: 4] == s[j*4 +: 4]) c++;
            end
        end
        c = c - b;
        return {3'(b), 3'(c)};
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        confirma = 1'b0;
        SW       = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // One confirm pulse; returns at the first negedge with busy low.
    task automatic press(input logic [15:0] code, output int nbusy);
        @(negedge clock);
        SW       = code;
        confirma = 1'b1;
        @(negedge clock);
        confirma = 1'b0;
        nbusy    = 0;
        while (busy === 1'b1 && nbusy < 50) begin
            nbusy++;
            @(negedge clock);
        end
        if (nbusy >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL press_timeout: busy still high after %0d cycles, required low", nbusy);
        end
    endtask

    task automatic push_guess(input logic [15:0] g, input logic [15:0] s,
                              input logic [7:0] t1, input logic [7:0] t2);
        exp_t e;
        logic [5:0] m;
        m    = model(g, s);
        e.b  = m[5:3];
        e.c  = m[2:0];
        e.t1 = t1;
        e.t2 = t2;
        sb.push_back(e);
    endtask

    task automatic check_guess(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sb_empty: got empty scoreboard, required an entry", name);
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (bulls !== e.b || cows !== e.c || tries_p1 !== e.t1 || tries_p2 !== e.t2 ||
            phase !== 3'd5) begin
            n_fail++;
            $display("FAIL %s_score: got b=%0d c=%0d t1=%0d t2=%0d ph=%0d required b=%0d c=%0d t1=%0d t2=%0d ph=5",
                     name, bulls, cows, tries_p1, tries_p2, phase, e.b, e.c, e.t1, e.t2);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        confirma = 1'b1;
        SW       = 16'h1234;
        @(negedge clock);
        n_checks++;
        if (phase !== 3'd0 || player !== 1'b0 || bulls !== 3'd0 || cows !== 3'd0 ||
            tries_p1 !== 8'd0 || tries_p2 !== 8'd0 || winner !== 1'b0 || invalid !== 1'b0 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got ph=%0d pl=%0d b=%0d c=%0d t1=%0d t2=%0d w=%0d inv=%0d busy=%0d required all 0",
                     phase, player, bulls, cows, tries_p1, tries_p2, winner, invalid, busy);
        end
        // Confirm held through release counts as a rise on the first edge.
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (phase !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_release_rise: got phase=%0d required 2", phase);
        end
        confirma = 1'b0;
        @(negedge clock);
        n_checks++;
        if (phase !== 3'd1) begin
            n_fail++;
            $display("FAIL reset_release_setup: got phase=%0d required 1", phase);
        end
    endtask

    task automatic test_invalid();
        int nb;
        logic [15:0] bad [2];
        bad[0] = 16'h1123;
        bad[1] = 16'h1F23;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            press(bad[i], nb);
            n_checks++;
            if (invalid !== 1'b1 || phase !== 3'd0 || nb != 1) begin
                n_fail++;
                $display("FAIL invalid_pulse_%0d: got inv=%0d ph=%0d busy=%0d required inv=1 ph=0 busy=1",
                         i, invalid, phase, nb);
            end
            @(negedge clock);
            n_checks++;
            if (invalid !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_width_%0d: got inv=%0d required 0", i, invalid);
            end
        end
        press(16'h1234, nb);
        n_checks++;
        if (phase !== 3'd1 || invalid !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_p1: got ph=%0d inv=%0d required ph=1 inv=0", phase, invalid);
        end
    endtask

    task automatic test_score();
        int nb;
        press(16'h5678, nb);
        n_checks++;
        if (phase !== 3'd3 || player !== 1'b0) begin
            n_fail++;
            $display("FAIL setup_p2: got ph=%0d pl=%0d required ph=3 pl=0", phase, player);
        end
        // Rejected guess must leave tries untouched and stay in GUESS.
        press(16'h5587, nb);
        n_checks++;
        if (invalid !== 1'b1 || phase !== 3'd3 || tries_p1 !== 8'd0) begin
            n_fail++;
            $display("FAIL guess_invalid: got inv=%0d ph=%0d t1=%0d required inv=1 ph=3 t1=0",
                     invalid, phase, tries_p1);
        end
        push_guess(16'h5687, 16'h5678, 8'd1, 8'd0);
        press(16'h5687, nb);
        n_checks++;
        if (nb != 5) begin
            n_fail++;
            $display("FAIL score_busy: got %0d busy cycles required 5", nb);
        end
        check_guess("p1_guess");
    endtask

    task automatic test_win();
        int nb;
        press(16'h0000, nb);
        n_checks++;
        if (phase !== 3'd3 || player !== 1'b1) begin
            n_fail++;
            $display("FAIL show_to_p2: got ph=%0d pl=%0d required ph=3 pl=1", phase, player);
        end
        push_guess(16'h1234, 16'h1234, 8'd1, 8'd1);
        press(16'h1234, nb);
        check_guess("p2_guess");
        press(16'h0000, nb);
        n_checks++;
        if (phase !== 3'd6 || winner !== 1'b1 || tries_p2 !== 8'd1) begin
            n_fail++;
            $display("FAIL win: got ph=%0d w=%0d t2=%0d required ph=6 w=1 t2=1",
                     phase, winner, tries_p2);
        end
        press(16'h0000, nb);
        n_checks++;
        if (phase !== 3'd0 || tries_p1 !== 8'd0 || tries_p2 !== 8'd0 || bulls !== 3'd0 ||
            cows !== 3'd0 || winner !== 1'b0 || player !== 1'b0) begin
            n_fail++;
            $display("FAIL win_restart: got ph=%0d t1=%0d t2=%0d b=%0d c=%0d w=%0d pl=%0d required all 0",
                     phase, tries_p1, tries_p2, bulls, cows, winner, player);
        end
    endtask

    task automatic test_draw();
        int nb;
        logic [15:0] g [4];
        g[0] = 16'h8765;
        g[1] = 16'h1243;
        g[2] = 16'h5670;
        g[3] = 16'h4321;
        do_reset();
        press(16'h1234, nb);
        press(16'h5678, nb);
        for (int i = 0; i < 4; i++) begin
            push_guess(g[i], (i % 2 == 0) ? 16'h5678 : 16'h1234,
                       8'((i + 2) / 2), 8'((i + 1) / 2));
            press(g[i], nb);
            check_guess($sformatf("draw_guess%0d", i));
            press(16'h0000, nb);
            if (i < 3) begin
                n_checks++;
                if (phase !== 3'd3 || player !== 1'((i + 1) % 2)) begin
                    n_fail++;
                    $display("FAIL draw_turn%0d: got ph=%0d pl=%0d required ph=3 pl=%0d",
                             i, phase, player, (i + 1) % 2);
                end
            end
        end
        n_checks++;
        if (phase !== 3'd7) begin
            n_fail++;
            $display("FAIL draw: got phase=%0d required 7", phase);
        end
        press(16'h0000, nb);
        n_checks++;
        if (phase !== 3'd0 || tries_p1 !== 8'd0 || tries_p2 !== 8'd0) begin
            n_fail++;
            $display("FAIL draw_restart: got ph=%0d t1=%0d t2=%0d required 0 0 0",
                     phase, tries_p1, tries_p2);
        end
    endtask

    task automatic test_held();
        int nval;
        do_reset();
        @(negedge clock);
        SW       = 16'h1234;
        confirma = 1'b1;
        nval     = 0;
        repeat (22) begin
            @(negedge clock);
            if (phase == 3'd2) nval++;
        end
        confirma = 1'b0;
        @(negedge clock);
        n_checks++;
        if (nval != 1 || phase !== 3'd1) begin
            n_fail++;
            $display("FAIL held_confirm: got validates=%0d ph=%0d required 1 and 1", nval, phase);
        end
    endtask

    task automatic test_reset_mid_score();
        int nb;
        int guard;
        do_reset();
        press(16'h1234, nb);
        press(16'h5678, nb);
        @(negedge clock);
        SW       = 16'h5687;
        confirma = 1'b1;
        @(negedge clock);
        confirma = 1'b0;
        guard    = 0;
        while (phase !== 3'd4 && guard < 10) begin
            guard++;
            @(negedge clock);
        end
        n_checks++;
        if (phase !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_score_enter: got phase=%0d required 4", phase);
        end
        // Now in the first SCORE cycle; two more edges reach the third.
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (phase !== 3'd0 || player !== 1'b0 || bulls !== 3'd0 || cows !== 3'd0 ||
            tries_p1 !== 8'd0 || tries_p2 !== 8'd0 || winner !== 1'b0 || invalid !== 1'b0 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_score_reset: got ph=%0d pl=%0d b=%0d c=%0d t1=%0d t2=%0d w=%0d inv=%0d busy=%0d required all 0",
                     phase, player, bulls, cows, tries_p1, tries_p2, winner, invalid, busy);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_score_release: got ph=%0d busy=%0d required 0 0", phase, busy);
        end
    endtask

    initial begin
        reset    = 1'b0;
        confirma = 1'b0;
        SW       = '0;
        test_reset();
        test_invalid();
        test_score();
        test_win();
        test_draw();
        test_held();
        test_reset_mid_score();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
